// File: rtl/pam_mul_sched.sv
// Round-robin scheduler sharing one nibble-serial 8x8 unsigned multiplier among NREQ requesters.
// Exact requests take two nibble passes; approximate ones take the high pass plus fixed compensation.
module pam_mul_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_x,
    input  logic [NREQ*8-1:0] req_y,
    input  logic [NREQ-1:0]   req_exact,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_z,
    output logic [IDW-1:0]    res_id,
    output logic              res_exact,
    output logic              busy
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high.
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     x_q, x_d;
    logic [7:0]     y_q, y_d;
    logic           exact_q, exact_d;
    logic [IDW-1:0] id_q, id_d;
    logic [15:0]    acc_q, acc_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [3:0]     nib;
    logic [11:0]    prod;
    logic [7:0]     sel_x;
    logic [7:0]     sel_y;

    // Fixed compensation for the truncated low-nibble partial products.
    function automatic logic [15:0] comp(input logic [7:0] x, input logic [7:0] y);
        logic c8, c9, c10, d9, d10;
        c8  = (x[0] & y[7]) | (x[1] & y[6]);
        c9  = (x[2] & y[6]) | (x[3] & y[5]);
        c10 = x[2] & y[7] & x[3] & y[6];
        d9  = (x[2] & y[7]) | (x[3] & y[6]);
        d10 = x[3] & y[7];
        return (16'(c8) << 8) + (16'(c9) << 9) + (16'(c10) << 10)
             + (16'(d9) << 9) + (16'(d10) << 10);
    endfunction

    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found;
    assign sel_x  = req_x[grant_idx*8 +: 8];
    assign sel_y  = req_y[grant_idx*8 +: 8];
    assign nib    = (state_q == S_LO) ? x_q[3:0] : x_q[7:4];
    assign prod   = 12'(y_q) * 12'(nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = req_exact[grant_idx] ? S_LO : S_HI;
            S_LO:   state_d = S_HI;
            S_HI:   state_d = S_DONE;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
        res_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        exact_d  = exact_q;
        id_d     = id_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: if (accept) begin
                rr_ptr_d = IDW'((int'(grant_idx) + 1) % NREQ);
                x_d      = sel_x;
                y_d      = sel_y;
                exact_d  = req_exact[grant_idx];
                id_d     = grant_idx;
                acc_d    = req_exact[grant_idx] ? 16'd0 : comp(sel_x, sel_y);
            end
            S_LO:   acc_d = 16'(prod);
            S_HI:   acc_d = acc_q + {prod, 4'b0000};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            exact_q  <= 1'b0;
            id_q     <= '0;
            acc_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            exact_q  <= exact_d;
            id_q     <= id_d;
            acc_q    <= acc_d;
        end
    end

    assign res_z     = acc_q;
    assign res_id    = id_q;
    assign res_exact = exact_q;

endmodule

// File: tb/tb_pam_mul_sched.sv
// Directed bench for pam_mul_sched: vector table for single transactions plus
// hand-written sequences for round-robin order, backpressure and mid-flight reset.
module tb_pam_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x;
  logic [NREQ*8-1:0] req_y;
  logic [NREQ-1:0]   req_exact;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_z;
  logic [IDW-1:0]    res_id;
  logic              res_exact;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pam_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_exact(req_exact),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_id(res_id), .res_exact(res_exact),
    .busy(busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        id;
    logic [7:0] x;
    logic [7:0] y;
    logic       ex;
    logic [15:0] z;
    int         lat;
  } vec_t;

  vec_t tab[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int g_cyc, output logic [NREQ-1:0] rdy);
    bit ok = 0;
    g_cyc = 0;
    rdy   = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1;
        g_cyc = cyc;
        rdy = req_ready;
        break;
      end
      tick();
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(output int r_cyc);
    bit ok = 0;
    r_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (res_valid) begin
        ok = 1;
        r_cyc = cyc;
        break;
      end
      tick();
    end
    if (!ok) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int gc, rc;
    logic [NREQ-1:0] rdy;
    tick();
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_x[v.id*8 +: 8] = v.x;
    req_y[v.id*8 +: 8] = v.y;
    req_exact[v.id] = v.ex;
    res_ready = 1'b1;
    wait_grant(gc, rdy);
    check("vec_grant", 32'(rdy), 32'(1 << v.id));
    tick();
    req_valid = '0;
    req_x = $urandom;
    req_y = $urandom;
    wait_res(rc);
    check("vec_latency", 32'(rc - gc), 32'(v.lat));
    check("vec_z", 32'(res_z), 32'(v.z));
    check("vec_id", 32'(res_id), 32'(v.id));
    check("vec_exact", 32'(res_exact), 32'(v.ex));
    tick();
    #1;
    check("vec_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int gc, rc, prev_gc, errs;
    logic [NREQ-1:0] rdy;
    logic [7:0]  t4_x[4];
    logic [7:0]  t4_y[4];
    logic [15:0] t4_z[4];
    int          t4_gap[4];

    tab[0] = '{id: 0, x: 8'hFF, y: 8'hFF, ex: 1'b1, z: 16'd65025, lat: 3};
    tab[1] = '{id: 0, x: 8'hFF, y: 8'hFF, ex: 1'b0, z: 16'd64528, lat: 2};
    tab[2] = '{id: 1, x: 8'h0F, y: 8'hFF, ex: 1'b0, z: 16'd3328,  lat: 2};
    tab[3] = '{id: 1, x: 8'h0F, y: 8'hFF, ex: 1'b1, z: 16'd3825,  lat: 3};
    tab[4] = '{id: 3, x: 8'h10, y: 8'h03, ex: 1'b0, z: 16'd48,    lat: 2};
    tab[5] = '{id: 2, x: 8'h12, y: 8'h34, ex: 1'b1, z: 16'd936,   lat: 3};
    tab[6] = '{id: 3, x: 8'hA5, y: 8'hC3, ex: 1'b0, z: 16'd32480, lat: 2};

    t4_x = '{8'h25, 8'h36, 8'h47, 8'h58};
    t4_y = '{8'h11, 8'h12, 8'h13, 8'h14};
    t4_z = '{16'd629, 16'd864, 16'd1349, 16'd1600};
    t4_gap = '{4, 3, 4, 3};

    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_exact = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_z", 32'(res_z), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_exact", 32'(res_exact), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tab[i]);

    // round-robin: all requesters pending, alternate exact/approx
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*8 +: 8] = t4_x[i];
      req_y[i*8 +: 8] = t4_y[i];
      req_exact[i] = (i % 2 == 0);
    end
    req_valid = '1;
    res_ready = 1'b1;
    prev_gc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(gc, rdy);
      check("rr_grant", 32'(rdy), 32'(1 << (n % NREQ)));
      if (n > 0) check("rr_interval", 32'(gc - prev_gc), 32'(t4_gap[(n - 1) % NREQ]));
      prev_gc = gc;
      tick();
      wait_res(rc);
      check("rr_id", 32'(res_id), 32'(n % NREQ));
      check("rr_z", 32'(res_z), 32'(t4_z[n % NREQ]));
      tick();
    end
    req_valid = '0;
    tick();

    // backpressure in DONE
    do_reset();
    req_x[8 +: 8]  = 8'hFF;  req_y[8 +: 8]  = 8'hFF;  req_exact[1] = 1'b0;
    req_x[16 +: 8] = 8'h0F;  req_y[16 +: 8] = 8'hFF;  req_exact[2] = 1'b1;
    req_valid = 4'b0110;
    res_ready = 1'b0;
    wait_grant(gc, rdy);
    check("bp_grant", 32'(rdy), 32'b0010);
    tick();
    req_valid = 4'b0100;
    wait_res(rc);
    check("bp_latency", 32'(rc - gc), 32'd2);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (!res_valid || res_z !== 16'd64528 || res_id !== 2'd1 || req_ready !== '0) errs++;
      tick();
      #1;
    end
    check("bp_hold_errors", 32'(errs), 32'd0);
    res_ready = 1'b1;
    #1;
    check("bp_no_grant_on_accept", 32'(req_ready), 32'd0);
    tick();
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    wait_res(rc);
    check("bp_second_z", 32'(res_z), 32'd3825);
    tick();

    // reset during LO: result dropped, rr_ptr back to 0
    do_reset();
    req_x[8 +: 8] = 8'd200;
    req_y[8 +: 8] = 8'd100;
    req_exact[1] = 1'b1;
    req_valid = 4'b0010;
    wait_grant(gc, rdy);
    check("rst_flight_grant", 32'(rdy), 32'b0010);
    tick();
    req_valid = '0;
    #1;
    check("rst_flight_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_flight_busy", 32'(busy), 32'd0);
    check("rst_flight_res_valid", 32'(res_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (res_valid !== 1'b0) errs++;
      tick();
    end
    check("rst_flight_no_result", 32'(errs), 32'd0);
    req_exact = '1;
    req_valid = '1;
    wait_grant(gc, rdy);
    check("rst_rr_ptr_zero", 32'(rdy), 32'b0001);
    tick();
    req_valid = '0;
    wait_res(rc);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
